// File: rtl/serial_addsub_pkg.sv
// Shared constants for the bit-serial NAND adder/subtractor.
// Latency: n/a (package). Backpressure: n/a.
// Holds the FSM state encoding and the bit-counter width helper.
package serial_addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // Counter width needed to index bits 0..width-1 (CNT_W = $clog2(WIDTH)).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_addsub_nand_fa.sv
// One-bit full adder built only from 2-input NAND gates.
// Latency: combinational. Backpressure: none.
// Ports: a, b, cin -> sum, cout.
module fa_nand (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic n_ab;    // ~(a & b), the inverted carry of the first half adder
  logic n_a;
  logic n_b;
  logic s_ab;    // a ^ b
  logic n_sc;    // ~(s_ab & cin), the inverted carry of the second half adder
  logic n_s;
  logic n_c;

  // First half adder: a + b
  nand g0 (n_ab, a, b);
  nand g1 (n_a, a, n_ab);
  nand g2 (n_b, b, n_ab);
  nand g3 (s_ab, n_a, n_b);

  // Second half adder: (a ^ b) + cin
  nand g4 (n_sc, s_ab, cin);
  nand g5 (n_s, s_ab, n_sc);
  nand g6 (n_c, cin, n_sc);
  nand g7 (sum, n_s, n_c);

  // OR of the two half-adder carries: NAND of their inverted forms
  nand g8 (cout, n_ab, n_sc);

endmodule

// File: rtl/serial_addsub_nand.sv
// Bit-serial WIDTH-bit add/sub through a single NAND full-adder cell, LSB first.
// Latency: WIDTH busy cycles after the accepting edge; done pulses the following cycle.
// Backpressure: start is ignored while busy=1; accepted in IDLE or DONE (back-to-back).
// Ports: clk, rst_n (sync, active-low), start/sub/a/b request, busy/done status,
//        result/carry_out/overflow held from done until the next accept or reset.
module serial_addsub_nand
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic             carry_q,  carry_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;

  logic fa_s;
  logic fa_c;

  fa_nand u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with sub.
          state_d  = RUN;
          a_sr_d   = a;
          b_sr_d   = b ^ {WIDTH{sub}};
          carry_d  = sub;
          cnt_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
        result_d = {fa_s, result_q[WIDTH-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = fa_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB, fa_c the carry out of it.
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_nand.sv
// Self-checking bench for serial_addsub_nand (WIDTH=8): arithmetic reference model
// plus directed literal cases, then randomized start/reset traffic.
module tb_serial_addsub_nand;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int n_cmp = 0;
  int n_bad = 0;

  serial_addsub_nand #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks cycles since the last accepted request and the arithmetic answer.
  bit m_valid  = 0;   // a reset edge has been seen
  bit m_active = 0;   // an operation was accepted since the last reset
  int m_k      = 0;   // cycles since the accepting edge (1 = first busy cycle)
  int m_res    = 0;
  int m_c      = 0;
  int m_v      = 0;

  always @(posedge clk) begin
    int ia, ib, raw, sa, sb, st;
    bit busy_now;
    if (!rst_n) begin
      m_valid  = 1;
      m_active = 0;
      m_k      = 0;
    end else if (m_valid) begin
      busy_now = m_active && (m_k >= 1) && (m_k <= W);
      if (start && !busy_now) begin
        ia = int'(a);
        ib = int'(b);
        if (sub) begin
          raw = ia - ib;
          m_c = (ia >= ib) ? 1 : 0;
        end else begin
          raw = ia + ib;
          m_c = (raw >= (1 << W)) ? 1 : 0;
        end
        m_res = raw & ((1 << W) - 1);
        sa = (ia >= (1 << (W-1))) ? ia - (1 << W) : ia;
        sb = (ib >= (1 << (W-1))) ? ib - (1 << W) : ib;
        st = sub ? (sa - sb) : (sa + sb);
        m_v = ((st > (1 << (W-1)) - 1) || (st < -(1 << (W-1)))) ? 1 : 0;
        m_active = 1;
        m_k      = 1;
      end else if (m_active && m_k < 1000) begin
        m_k++;
      end
    end
  end

  // Compare process: every cycle once reset has been applied.
  always @(negedge clk) begin
    int j, e_res;
    if (m_valid) begin
      if (!m_active) begin
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_result", 32'(result), 0);
        chk("idle_carry", 32'(carry_out), 0);
        chk("idle_ovf", 32'(overflow), 0);
      end else if (m_k <= W) begin
        // k-1 sum bits have been shifted in from the top so far.
        j = m_k - 1;
        e_res = ((m_res & ((1 << j) - 1)) << (W - j)) & ((1 << W) - 1);
        chk("run_busy", 32'(busy), 1);
        chk("run_done", 32'(done), 0);
        chk("run_partial_result", 32'(result), 32'(e_res));
        chk("run_carry", 32'(carry_out), 0);
        chk("run_ovf", 32'(overflow), 0);
      end else begin
        chk("res_busy", 32'(busy), 0);
        chk("res_done", 32'(done), (m_k == W + 1) ? 1 : 0);
        chk("res_result", 32'(result), 32'(m_res));
        chk("res_carry", 32'(carry_out), 32'(m_c));
        chk("res_ovf", 32'(overflow), 32'(m_v));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_start(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
    @(posedge clk); #2;
    start = 1'b1; a = ia; b = ib; sub = isub;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #2;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
  endtask

  // Called a little after an edge in cycle 'cur'; returns the cycle in which
  // done was seen (-1 on timeout) and how many busy cycles were observed.
  task automatic wait_done(input int cur, output int dcyc, output int bcnt);
    dcyc = -1;
    bcnt = 0;
    for (int i = 0; i < 4 * W && dcyc < 0; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) dcyc = cur + i;
    end
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                        input logic [W-1:0] er, input logic ec, input logic ev, input string nm);
    int dc, bc;
    drive_start(ia, ib, isub);
    idle_cycle();
    wait_done(1, dc, bc);
    chk({nm, "_done_cycle"}, 32'(dc), W + 1);
    chk({nm, "_busy_cycles"}, 32'(bc), W);
    chk({nm, "_result"}, 32'(result), 32'(er));
    chk({nm, "_carry"}, 32'(carry_out), 32'(ec));
    chk({nm, "_ovf"}, 32'(overflow), 32'(ev));
  endtask

  initial begin
    int dc, bc;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed, hand-computed cases
    run_op(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, "add_3c_5a");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");

    // start re-pulsed in cycle 3 of a run is ignored
    drive_start(8'h10, 8'h20, 1'b0);
    idle_cycle();
    idle_cycle();
    @(posedge clk); #2;
    start = 1'b1; a = 8'h77; b = 8'h11; sub = 1'b1;
    idle_cycle();
    wait_done(4, dc, bc);
    chk("ignore_done_cycle", 32'(dc), W + 1);
    chk("ignore_result", 32'(result), 32'h30);
    chk("ignore_carry", 32'(carry_out), 0);
    chk("ignore_ovf", 32'(overflow), 0);

    // reset asserted in cycle 4 of a run aborts it
    drive_start(8'h55, 8'h33, 1'b0);
    idle_cycle();
    idle_cycle();
    idle_cycle();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_result", 32'(result), 0);
    chk("abort_carry", 32'(carry_out), 0);
    bc = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) bc++;
    end
    chk("abort_no_done", 32'(bc), 0);
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "add_after_reset");

    // back-to-back: start held in the DONE cycle
    drive_start(8'h11, 8'h22, 1'b0);
    idle_cycle();
    wait_done(1, dc, bc);
    chk("b2b_first_done_cycle", 32'(dc), W + 1);
    chk("b2b_first_result", 32'(result), 32'h33);
    start = 1'b1; a = 8'h0F; b = 8'h0F; sub = 1'b1;
    idle_cycle();
    @(negedge clk);
    chk("b2b_busy_rises", 32'(busy), 1);
    wait_done(2, dc, bc);
    chk("b2b_second_done_cycle", 32'(dc), W + 1);
    chk("b2b_second_result", 32'(result), 32'h00);
    chk("b2b_second_carry", 32'(carry_out), 1);
    chk("b2b_second_ovf", 32'(overflow), 0);

    // Randomized traffic, including occasional resets; checked by the model
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      rst_n = ($urandom_range(0, 149) != 0);
      start = ($urandom_range(0, 2) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
    end
    @(posedge clk); #2;
    rst_n = 1'b1; start = 1'b0;
    repeat (2 * W + 4) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub_nand.md
Name: serial_addsub_nand

Overview:
Bit-serial WIDTH-bit adder/subtractor that consumes one NAND-only full-adder cell per clock, LSB first, with a registered carry between bits. Operands load in parallel on a start handshake. The result, carry/borrow flag and signed-overflow flag are presented in parallel after WIDTH processing cycles. It is the sequential stage downstream of the team's NAND adder/subtractor cells and trades latency for a single-cell datapath.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  synchronous, active-low reset.
start  input  1  request; sampled only when busy=0.
sub  input  1  0 = a+b, 1 = a-b; sampled with start.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse when result/flags become valid.
result  output  WIDTH  sum or difference, modulo 2^WIDTH.
carry_out  output  1  final carry. For sub, 1 = no borrow (a >= b unsigned).
overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset: a clock edge with rst_n=0 forces state=IDLE and clears every output: busy=0, done=0, result=0, carry_out=0, overflow=0. All internal shift registers, carry and counter also clear. Reset aborts an operation in progress, and no done pulse is produced for it.
- FSM states are IDLE, RUN and DONE.
  - IDLE/DONE -> RUN on a start=1 edge.
  - RUN -> DONE on the edge that processes bit WIDTH-1.
  - DONE -> IDLE on the next edge if start=0.
- Accept: on a start=1 edge in IDLE or DONE:
  - a_sr <= a; b_sr <= b XOR {WIDTH{sub}}; carry <= sub; bit_cnt <= 0.
  - result, carry_out and overflow are cleared.
- RUN, each edge:
  - The full adder takes (a_sr[0], b_sr[0], carry) and produces s and c.
  - result <= {s, result[WIDTH-1:1]}; a_sr and b_sr shift right; carry <= c; bit_cnt++.
- Last bit (bit_cnt == WIDTH-1):
  - carry_out <= c; overflow <= carry XOR c, i.e. carry into the MSB XOR carry out of the MSB.
  - bit_cnt returns to 0.
- Timing, with start accepted at the end of cycle 0:
  - busy=1 in cycles 1..WIDTH.
  - done=1 only in cycle WIDTH+1.
  - result and flags are valid from cycle WIDTH+1 and held until the next accept or reset.
- start while busy=1 is ignored and does not alter operands or sub.
- start=1 in the DONE cycle is accepted back-to-back: done pulses that cycle and busy rises the next cycle.
- a, b and sub may change freely after the accept edge.
- The datapath is one instance of the NAND-only full adder. The only storage is flops for state, counter, shift registers, carry and flags.

Decomposition:
- Package serial_addsub_pkg holds:
  - state encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - localparam CNT_W = $clog2(WIDTH).
- Sub-module fa_nand (a, b, cin -> sum, cout) is built purely from 2-input nand primitives: two NAND half-adders plus a NAND-realised OR of the two carries. It is instantiated once.

Test Plan:
- WIDTH=8, add 0x3C+0x5A -> result=0x96, carry_out=0, overflow=1; busy high exactly 8 cycles; done single pulse in cycle 9.
- Add 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0.
- Sub 0x05-0x07 -> result=0xFE, carry_out=0 (borrow), overflow=0. Sub 0x80-0x01 -> result=0x7F, carry_out=1, overflow=1.
- start pulsed again with new operands in cycle 3 of a 0x10+0x20 run -> ignored; result=0x30 and done in cycle 9.
- rst_n=0 in cycle 4 of a run -> the next cycle shows all outputs 0, state IDLE and no done. A following 0x01+0x01 gives result=0x02.
- start held during the DONE cycle of 0x11+0x22 with new operands 0x0F-0x0F -> first done shows 0x33. busy rises the next cycle, and the second result is 0x00 with carry_out=1 and overflow=0.
